spi_shift_engine: RTL
=====================

SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 Parameter F_SIZE, default 8: bits per frame.
REQ-002 Parameter DEPTH, default 4: TX FIFO entries, power of two, >=2.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst  input  1: reset, synchronous and active-high.
REQ-005 cs_i  input  1: chip select from SPI master FSM, active-low; clk-synchronous.
REQ-006 sclk_i  input  1: gated SCLK from SPI master FSM, idle low (mode 0); clk-synchronous.
REQ-007 miso_i  input  1: serial data from slave.
REQ-008 tx_data_i  input  F_SIZE: frame to transmit.
REQ-009 tx_valid_i  input  1: tx_data_i valid.
REQ-010 tx_ready_o  output  1: FIFO can accept a frame.
REQ-011 mosi_o  output  1: serial data to slave, registered.
REQ-012 rx_data_o  output  F_SIZE: last received frame.
REQ-013 rx_valid_o  output  1: one-clk pulse, rx_data_o updated.
REQ-014 busy_o  output  1: high while state is not IDLE.
REQ-015 underrun_o  output  1: sticky, a frame was loaded from an empty FIFO.

Function
REQ-016 Edge detect: sclk_q, cs_q registered copies; rise = sclk_i & ~sclk_q, fall = ~sclk_i & sclk_q, cs_fall = ~cs_i & cs_q, cs_rise = cs_i & ~cs_q.
REQ-017 TX FIFO: push on tx_valid_i & tx_ready_o; tx_ready_o = ~full; no bypass; pop only on frame load.
REQ-018 Push and pop in same clk when non-empty, non-full: count unchanged, both take effect.
REQ-019 Pop with FIFO empty: shift register loads all-zero, underrun_o set; a same-cycle push is still stored.
REQ-020 States: IDLE, SHIFT.
REQ-021 IDLE -> SHIFT on cs_fall: load shift register from FIFO head (pop), mosi_o = loaded MSB, bit_cnt = 0.
REQ-022 SHIFT, rise: sample miso_i into rx shift register LSB (shift left), bit_cnt + 1.
REQ-023 SHIFT, fall with bit_cnt < F_SIZE: shift TX register left, mosi_o = new MSB.
REQ-024 SHIFT, fall with bit_cnt == F_SIZE: rx_data_o <= rx shift register, rx_valid_o high next clk for exactly one clk; reload TX from FIFO (pop), mosi_o = new MSB, bit_cnt = 0.
REQ-025 SHIFT -> IDLE on cs_rise: mosi_o = 0; partial frame (0 < bit_cnt < F_SIZE) discarded, no rx_valid_o; TX word already popped is lost.
REQ-026 cs_rise and fall in same clk: fall processed first (frame may complete), then IDLE.
REQ-027 rise/fall events ignored in IDLE; cs_fall ignored in SHIFT.
REQ-028 MSB first on both MOSI and MISO.
REQ-029 bit_cnt width $clog2(F_SIZE)+1; FIFO pointers wrap modulo DEPTH; count width $clog2(DEPTH)+1.

Reset
REQ-030 On rst: state IDLE, FIFO empty, tx_ready_o 1, mosi_o 0, rx_data_o 0, rx_valid_o 0, busy_o 0, underrun_o 0, bit_cnt 0, sclk_q 0, cs_q 1.
REQ-031 rst mid-frame aborts immediately; FIFO contents dropped; no rx_valid_o.
REQ-032 underrun_o cleared only by rst.

Configuration
REQ-033 Macro SPI_SHIFT_RX_EN: defined -> MISO capture, rx_data_o, rx_valid_o as above.
REQ-034 SPI_SHIFT_RX_EN undefined -> no RX shift register; rx_data_o tied 0, rx_valid_o tied 0; TX behaviour unchanged.

Verification
REQ-035 Push 0xA5, drive cs_i low, 8 SCLK pulses -> mosi_o sequence 1,0,1,0,0,1,0,1 stable at each rise; FIFO empty after.
REQ-036 SPI_SHIFT_RX_EN, miso_i drives 0x3C over 8 rises -> rx_data_o = 0x3C, rx_valid_o one clk after 8th fall.
REQ-037 Push 0x11,0x22,0x33,0x44 -> tx_ready_o 0; fifth push not accepted; two frames in one CS window -> 0x11 then 0x22 shifted back-to-back, tx_ready_o 1.
REQ-038 cs_i low with FIFO empty -> mosi_o all zeros, underrun_o 1 until rst.
REQ-039 cs_i high after 3 SCLK pulses -> IDLE, mosi_o 0, no rx_valid_o; next frame starts from next FIFO entry.
REQ-040 rst asserted after 4 bits with 2 frames queued -> all outputs at reset values next clk, tx_ready_o 1.

Source files
------------

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - SPI mode-0 shift engine with TX FIFO and optional RX capture
//
// Purpose:
//   Serialises frames from a small TX FIFO onto mosi_o, MSB first, under
//   the control of a clk-synchronous chip select and gated SCLK from an
//   SPI master FSM. Optionally captures miso_i into received frames.
//
// Configuration:
//   SPI_SHIFT_RX_EN - when defined, MISO capture drives rx_data_o/rx_valid_o;
//                     when undefined, both are tied to zero.
//
// Ports:
//   clk, rst     - clock; synchronous active-high reset
//   cs_i         - chip select, active-low
//   sclk_i       - gated SCLK, idle low
//   miso_i       - serial data from slave
//   tx_data_i    - frame to transmit
//   tx_valid_i   - tx_data_i valid
//   tx_ready_o   - FIFO can accept a frame
//   mosi_o       - registered serial data to slave
//   rx_data_o    - last received frame
//   rx_valid_o   - one-clk pulse when rx_data_o updates
//   busy_o       - engine is in a CS window
//   underrun_o   - sticky: a frame was loaded from an empty FIFO
module spi_shift_engine #(
    parameter int F_SIZE = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_i,
    input  logic              sclk_i,
    input  logic              miso_i,
    input  logic [F_SIZE-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic              mosi_o,
    output logic [F_SIZE-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              busy_o,
    output logic              underrun_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(F_SIZE) + 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state_q, state_d;
    logic              sclk_q, cs_q;
    logic [F_SIZE-1:0] fifo_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic [F_SIZE-1:0] tx_sh_q, tx_sh_d;
    logic              mosi_q, mosi_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              underrun_q;

    logic              rise, fall, cs_fall, cs_rise;
    logic              full, empty, push, pop, pop_ok;
    logic [F_SIZE-1:0] load_word, tx_shifted;
    logic              sample, frame_done;

    assign rise    = sclk_i & ~sclk_q;
    assign fall    = ~sclk_i & sclk_q;
    assign cs_fall = ~cs_i & cs_q;
    assign cs_rise = cs_i & ~cs_q;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign push   = tx_valid_i & ~full;
    assign pop_ok = pop & ~empty;

    // An empty FIFO yields an all-zero frame rather than stale memory.
    assign load_word  = empty ? '0 : fifo_q[rd_ptr_q];
    assign tx_shifted = {tx_sh_q[F_SIZE-2:0], 1'b0};

    assign count_d = count_q + CW'(push) - CW'(pop_ok);

    always_comb begin
        state_d    = state_q;
        tx_sh_d    = tx_sh_q;
        mosi_d     = mosi_q;
        bit_cnt_d  = bit_cnt_q;
        pop        = 1'b0;
        sample     = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = SHIFT;
                    pop       = 1'b1;
                    tx_sh_d   = load_word;
                    mosi_d    = load_word[F_SIZE-1];
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (rise) begin
                    sample    = 1'b1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end else if (fall) begin
                    if (bit_cnt_q == BW'(F_SIZE)) begin
                        // Frame complete: hand off RX and chain the next TX word.
                        frame_done = 1'b1;
                        pop        = 1'b1;
                        tx_sh_d    = load_word;
                        mosi_d     = load_word[F_SIZE-1];
                        bit_cnt_d  = '0;
                    end else begin
                        tx_sh_d = tx_shifted;
                        mosi_d  = tx_shifted[F_SIZE-1];
                    end
                end
                // Evaluated after the fall so a coincident final fall still completes.
                if (cs_rise) begin
                    state_d   = IDLE;
                    mosi_d    = 1'b0;
                    bit_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sclk_q     <= 1'b0;
            cs_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_sh_q    <= '0;
            mosi_q     <= 1'b0;
            bit_cnt_q  <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sclk_q    <= sclk_i;
            cs_q      <= cs_i;
            tx_sh_q   <= tx_sh_d;
            mosi_q    <= mosi_d;
            bit_cnt_q <= bit_cnt_d;
            count_q   <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (pop & empty) begin
                underrun_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= tx_data_i;
        end
    end

    assign tx_ready_o = ~full;
    assign mosi_o     = mosi_q;
    assign busy_o     = (state_q != IDLE);
    assign underrun_o = underrun_q;

`ifdef SPI_SHIFT_RX_EN
    logic [F_SIZE-1:0] rx_sh_q, rx_data_q;
    logic              rx_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            if (sample) begin
                rx_sh_q <= {rx_sh_q[F_SIZE-2:0], miso_i};
            end
            if (frame_done) begin
                rx_data_q <= rx_sh_q;
            end
            rx_valid_q <= frame_done;
        end
    end

    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
`else
    logic unused_rx;
    assign unused_rx  = ^{miso_i, sample, frame_done};
    assign rx_data_o  = '0;
    assign rx_valid_o = 1'b0;
`endif

endmodule
